// File: rtl/arb16b2_pkg.sv
// Shared encodings for the two-requester arbiter and its select path.
// Owner/source codes double as the mux select value (A = 0, B = 1).
// State codes are plain 2-bit constants so netlists and old tooling can read them.
package arb16b2_pkg;

  // Requester / source identifiers; also the value driven on the mux select.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Arbiter FSM states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN_A = 2'd1;
  localparam logic [1:0] ST_OWN_B = 2'd2;

  // Default data width of the shared select path.
  localparam int DEF_WIDTH = 16;

endpackage

// File: rtl/mux16b2.sv
// Purpose: 2:1 data select for the shared 16-bit path; y = s ? b : a.
// Latency: combinational. Backpressure: none (pure datapath).
// Ports: a, b - data inputs; s - select (0 = a, 1 = b); y - selected data.
module mux16b2 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/arb16b2.sv
// Purpose: round-robin arbiter/sequencer for two burst requesters sharing mux16b2,
//          feeding a one-entry registered output stage.
// Latency: one cycle to grant from IDLE; one cycle from accepted beat to r_valid.
// Backpressure: r_valid && !r_ready drops both readies and freezes FSM and burst count.
// Ports: clk/rst (async, active-high); a_*/b_* requester beats with valid/ready/last;
//        s - select to the mux (current owner); r_* - registered output beat and source.
module arb16b2
  import arb16b2_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  input  logic             a_last,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  input  logic             b_last,
  output logic             b_ready,
  output logic             s,
  output logic [WIDTH-1:0] r_data,
  output logic             r_src,
  output logic             r_valid,
  input  logic             r_ready
);

  // Beat counter holds up to 15, the largest legal burst limit.
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  logic [1:0]       state_q, state_d;
  logic             rr_q, rr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             s_q, s_d;
  logic [WIDTH-1:0] r_data_q;
  logic             r_src_q;
  logic             r_valid_q;

  logic [WIDTH-1:0] mux_y;
  logic             out_free;
  logic             owner_b;
  logic             accept;
  logic             cur_last;
  logic             other_valid;
  logic             limit_hit;
  logic             release_own;

  // Data select: the select is the registered owner, so the mux path is glitch-free.
  mux16b2 #(.WIDTH(WIDTH)) u_mux (
    .a (a_data),
    .b (b_data),
    .s (s_q),
    .y (mux_y)
  );

  // Output stage can take a beat when empty or being drained this cycle.
  assign out_free = !r_valid_q || r_ready;
  assign a_ready  = (state_q == ST_OWN_A) && out_free;
  assign b_ready  = (state_q == ST_OWN_B) && out_free;
  assign accept   = (a_valid && a_ready) || (b_valid && b_ready);

  assign owner_b     = (state_q == ST_OWN_B);
  assign cur_last    = owner_b ? b_last : a_last;
  assign other_valid = owner_b ? a_valid : b_valid;

  // ">=" rather than "==" so an owner whose count has saturated (other side was
  // idle at the limit) still yields as soon as the other side shows up.
  assign limit_hit   = ({1'b0, cnt_q} + 5'd1) >= {1'b0, BURST_MAX};
  assign release_own = accept && (cur_last || (limit_hit && other_valid));

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    s_d     = s_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 4'd0;
        if (a_valid && (!b_valid || rr_q == SRC_A)) begin
          state_d = ST_OWN_A;
        end else if (b_valid) begin
          state_d = ST_OWN_B;
        end
      end
      ST_OWN_A, ST_OWN_B: begin
        if (release_own) begin
          rr_d    = owner_b ? SRC_A : SRC_B;
          cnt_d   = 4'd0;
          // Hand straight over to a waiting requester; no IDLE bubble.
          if (other_valid) begin
            state_d = owner_b ? ST_OWN_A : ST_OWN_B;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (accept && cnt_q < BURST_MAX) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Select follows the owner; IDLE keeps whatever side last owned the path.
    if (state_d == ST_OWN_A) begin
      s_d = SRC_A;
    end else if (state_d == ST_OWN_B) begin
      s_d = SRC_B;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= SRC_A;
      cnt_q   <= 4'd0;
      s_q     <= SRC_A;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_q  <= '0;
      r_src_q   <= SRC_A;
      r_valid_q <= 1'b0;
    end else if (accept) begin
      r_data_q  <= mux_y;
      r_src_q   <= s_q;
      r_valid_q <= 1'b1;
    end else if (r_ready) begin
      r_valid_q <= 1'b0;
    end
  end

  assign s       = s_q;
  assign r_data  = r_data_q;
  assign r_src   = r_src_q;
  assign r_valid = r_valid_q;

endmodule

// File: doc/arb16b2.md
Name: arb16b2

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 16-bit 2:1 select path (mux16b2).
- Grants one requester at a time and drives the select.
- Moves beats through a one-entry registered output stage using valid/ready handshakes.
- Releases ownership on a last-beat marker, or on a burst limit when the other side is waiting.

Parameters:
- WIDTH, 16, data width of every data port.
- MAX_BURST, 4, maximum beats per grant while the other requester is waiting (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- a_data  input  WIDTH  requester A beat data.
- a_valid  input  1  requester A beat present.
- a_last  input  1  marks A's final beat of a burst.
- a_ready  output  1  A beat accepted this cycle when a_valid && a_ready.
- b_data  input  WIDTH  requester B beat data.
- b_valid  input  1  requester B beat present.
- b_last  input  1  marks B's final beat of a burst.
- b_ready  output  1  B beat accepted this cycle when b_valid && b_ready.
- s  output  1  select to mux16b2: 0 = A, 1 = B; equals current owner.
- r_data  output  WIDTH  registered output beat.
- r_src  output  1  source of r_data: 0 = A, 1 = B.
- r_valid  output  1  output beat present.
- r_ready  input  1  downstream accepts when r_valid && r_ready.

Behaviour:
- Reset, asynchronous on rst high:
  - State = IDLE, rr pointer = A, beat count = 0.
  - s = 0, r_data = 0, r_src = 0, r_valid = 0, a_ready = 0, b_ready = 0.
- FSM states: IDLE, OWN_A, OWN_B. s = 1 only in OWN_B; IDLE holds the last s value (0 after reset).
- IDLE transitions:
  - Only a_valid → OWN_A next cycle.
  - Only b_valid → OWN_B next cycle.
  - Both → the side the rr pointer names.
  - Neither → stay in IDLE.
  - The grant costs one cycle; no beat is accepted in IDLE.
- Readiness:
  - a_ready = (state == OWN_A) && (!r_valid || r_ready).
  - b_ready is symmetric.
  - Both are combinational from state and the output stage; never both high.
- Accept:
  - On an accepted beat, r_data <= x_data, r_src <= owner, r_valid <= 1 at the next edge.
  - Latency from accept to r_valid is 1 cycle.
  - Full throughput: one beat per cycle while r_ready stays high.
- Drain: r_valid clears when r_ready is high and no beat is accepted that cycle. r_data holds while r_valid && !r_ready.
- Beat count:
  - Increments per accepted beat of the owner.
  - Resets to 0 on any owner change or entry to IDLE.
- Release, evaluated on the accepting edge:
  - Condition: accepted beat has x_last = 1, OR (count + 1 == MAX_BURST and the other side's valid = 1).
  - Next state is the other side if its valid = 1, else IDLE.
  - rr pointer <= other side.
  - Direct OWN_A → OWN_B switch with no IDLE bubble.
- No release otherwise, including when the owner drops valid mid-burst: ownership is held (lock) until last or the burst limit.
- Burst limit reached with the other side idle: no release, count saturates at MAX_BURST; the owner continues.
- Simultaneous release and other-side request in the same cycle: the switch happens; the first beat of the new owner is accepted on the following cycle at earliest.
- Backpressure: with r_valid = 1 and r_ready = 0, both readies are 0; state and count freeze.
- Reset mid-burst: all state is discarded immediately and any in-flight r_valid beat is dropped. Requesters re-request after release.

Decomposition:
- Shared package/include holds:
  - Owner encodings SRC_A = 1'b0, SRC_B = 1'b1.
  - State encodings ST_IDLE = 2'd0, ST_OWN_A = 2'd1, ST_OWN_B = 2'd2.
  - Default WIDTH = 16.
- Instantiate the existing mux16b2 for the data select (s drives its s). The output register and FSM stay in arb16b2.

Test Plan:
- Reset then idle: rst high 2 cycles, no valids → r_valid = 0, a_ready = b_ready = 0, s = 0 throughout.
- Single A burst: a_data = 16'h1111, 16'h2222, 16'h3333 with a_last on the third, r_ready = 1 → r_data sequence 1111, 2222, 3333 with r_src = 0, one per cycle, first r_valid 2 cycles after a_valid; then state IDLE.
- Contention and round-robin: a_valid = b_valid = 1 from reset, 1-beat bursts (last = 1), A = 16'h00AA, B = 16'h00BB → outputs alternate AA, BB, AA, BB; A first.
- Burst limit: A streams 6 beats without last, B valid from cycle 0 → after A's 4th beat s switches to 1; B's beats appear next; A resumes after B's last.
- Backpressure: mid-burst r_ready = 0 for 3 cycles → a_ready = 0, r_data holds its value, no beat lost or duplicated, count unchanged.
- Reset mid-burst: assert rst after A's 2nd beat → all outputs 0 asynchronously. After release with b_valid only → OWN_B, s = 1.
